// File: rtl/moore_seq_pkg.sv
// Shared types, configuration reset defaults and the length clamp helper
// for the programmable Moore sequence detector.
package moore_seq_pkg;

    // Generic length type, wide enough for any practical MAX_LEN; callers
    // cast into their own LEN_W-bit fields.
    localparam int unsigned LEN_T_W = 16;
    typedef logic [LEN_T_W-1:0] len_t;

    // Configuration register reset values. The reset length is MAX_LEN,
    // which depends on the instance parameter and lives in the top.
    localparam logic RST_OVERLAP     = 1'b1;
    localparam logic RST_PATTERN_BIT = 1'b0;

    // A zero length would make every state an accept state, so it is stored
    // as 1; anything beyond the pattern register is stored as the maximum.
    function automatic len_t clamp_len(input len_t raw, input len_t max_len);
        if (raw == '0) begin
            return len_t'(1);
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/seq_prefix_matcher.sv
// Combinational next-state search: the longest pattern prefix that equals a
// suffix of the received stream, including the bit arriving this cycle.
module seq_prefix_matcher
    import moore_seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN:0]   ext_hist_i,   // {hist, bit_in}, bit_in at [0]
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   state_i,
    input  logic               restart_i,    // non-overlap restart after accept
    output logic [LEN_W-1:0]   next_state_o
);

    int                 len_v;
    int                 bound_v;
    logic [MAX_LEN:0]   mask_v;
    logic [MAX_LEN:0]   aligned_v;

    // Priority search over k = 1..MAX_LEN; the largest matching k wins.
    // A prefix of length k can only match if the prefix of length k-1
    // matched before this bit, so k never exceeds state+1. That bound keeps
    // stale or reset-zero history bits from producing phantom matches, and
    // a restart collapses it to 1 so only the new bit is considered.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        next_state_o = '0;
        mask_v       = '0;
        aligned_v    = '0;
        len_v        = int'(len_i);
        if (restart_i) begin
            bound_v = 1;
        end else if (int'(state_i) + 1 < len_v) begin
            bound_v = int'(state_i) + 1;
        end else begin
            bound_v = len_v;
        end

        for (int k = 1; k <= MAX_LEN; k++) begin
            // Low k bits set.
            mask_v    = {(MAX_LEN + 1){1'b1}} >> (MAX_LEN + 1 - k);
            // pat[len-1 -: k] moved down to bits [k-1:0].
            aligned_v = {1'b0, pat_i} >> (len_v - k);
            if ((k <= bound_v) && (((ext_hist_i ^ aligned_v) & mask_v) == '0)) begin
                next_state_o = LEN_W'(k);
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with runtime pattern, length and overlap
// mode, and a saturating count of accept-state entries.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               bit_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   state_o
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // Configuration registers
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;

    // Run state
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN:0]   ext_hist;
    logic [LEN_W-1:0]   next_state;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               restart;
    logic               accept_q;

    assign ext_hist        = {hist_q, bit_in};
    assign accept_q        = (state_q == len_q);
    // Without overlap, leaving accept forgets everything received so far.
    assign restart         = !overlap_q && accept_q;
    assign cfg_len_clamped = LEN_W'(clamp_len(len_t'(cfg_len), len_t'(MAX_LEN)));

    seq_prefix_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .ext_hist_i   (ext_hist),
        .pat_i        (pat_q),
        .len_i        (len_q),
        .state_i      (state_q),
        .restart_i    (restart),
        .next_state_o (next_state)
    );

    // Next-state logic: configuration load beats a valid input bit.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        state_d   = state_q;
        count_d   = count_q;

        if (cfg_load) begin
            pat_d     = cfg_pattern;
            len_d     = cfg_len_clamped;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            state_d   = '0;
            count_d   = '0;
        end else if (en) begin
            hist_d  = ext_hist[MAX_LEN-1:0];
            state_d = next_state;
            // Every entry into accept counts, including accept -> accept.
            if ((next_state == len_q) && (count_q != CNT_SAT)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of its inputs regardless of statement order.
        if (rst) begin
            pat_q     <= {MAX_LEN{RST_PATTERN_BIT}};
            len_q     <= LEN_MAX;
            overlap_q <= RST_OVERLAP;
            // NOTE: the history register is reset along with the state; the
            // matcher never trusts it beyond state+1 bits, but a defined
            // value keeps the debug view and equivalence checks clean.
            hist_q    <= '0;
            state_q   <= '0;
            count_q   <= '0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            count_q   <= count_d;
        end
    end

    // Moore outputs come straight from registers.
    assign match       = accept_q;
    assign match_count = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs for each
// observed cycle; an independent monitor pops and compares after the edge.
module tb_moore_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic       ld0 = 1'b0, ld1 = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b1;

    logic       match0, match1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [3:0] st0, st1;

    always #5 clk = ~clk;

    moore_seq_detector #(.MAX_LEN(8), .CNT_W(8)) u_dut0 (
        .clk (clk), .rst (rst), .en (en0), .bit_in (bit_in),
        .cfg_load (ld0), .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
        .cfg_overlap (cfg_overlap), .match (match0), .match_count (cnt0),
        .state_o (st0)
    );

    moore_seq_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut1 (
        .clk (clk), .rst (rst), .en (en1), .bit_in (bit_in),
        .cfg_load (ld1), .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
        .cfg_overlap (cfg_overlap), .match (match1), .match_count (cnt1),
        .state_o (st1)
    );

    typedef struct {
        bit    sel;
        bit    m;
        int    s;
        int    c;
        string name;
    } exp_t;

    exp_t exp_q[$];
    bit   obs_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Monitor: after every edge where the driver flagged an observation.
    always @(posedge clk) begin
        bit   want;
        exp_t e;
        logic am;
        int   as_v, ac_v;
        want = obs_req;
        #1;
        if (want) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, required an entry");
            end else begin
                e    = exp_q.pop_front();
                am   = e.sel ? match1 : match0;
                as_v = e.sel ? int'(st1) : int'(st0);
                ac_v = e.sel ? int'(cnt1) : int'(cnt0);
                if (am !== e.m || as_v != e.s || ac_v != e.c) begin
                    n_fail++;
                    $display("FAIL %s: got match=%0b state=%0d count=%0d, required match=%0b state=%0d count=%0d",
                             e.name, am, as_v, ac_v, e.m, e.s, e.c);
                end
            end
        end
    end

    // One clock of stimulus with its expected post-edge outputs.
    task automatic cyc(input bit sel, input bit e, input bit b, input bit ld, input bit r,
                       input bit m, input int s, input int c, input string name);
        exp_t x;
        en0    = e && !sel;
        en1    = e && sel;
        ld0    = ld && !sel;
        ld1    = ld && sel;
        rst    = r;
        bit_in = b;
        x.sel = sel; x.m = m; x.s = s; x.c = c; x.name = name;
        exp_q.push_back(x);
        obs_req = 1'b1;
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0; ld0 = 1'b0; ld1 = 1'b0; rst = 1'b0;
        obs_req = 1'b0;
    endtask

    task automatic feed(input bit sel, input bit b, input bit m, input int s, input int c,
                        input string name);
        cyc(sel, 1'b1, b, 1'b0, 1'b0, m, s, c, name);
    endtask

    task automatic idle(input bit sel, input bit m, input int s, input int c, input string name);
        cyc(sel, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, m, s, c, name);
    endtask

    task automatic load(input bit sel, input logic [7:0] p, input logic [3:0] l, input bit ov,
                        input string name);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cyc(sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vec;
        @(negedge clk);

        // Reset state of both instances
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "reset_dut0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "reset_dut1");

        // Overlap on: 1011 over 1,0,1,1,0,1,1
        load(1'b0, 8'b0000_1011, 4'd4, 1'b1, "ovl_load");
        feed(1'b0, 1'b1, 1'b0, 1, 0, "ovl_b1");
        feed(1'b0, 1'b0, 1'b0, 2, 0, "ovl_b2");
        feed(1'b0, 1'b1, 1'b0, 3, 0, "ovl_b3");
        feed(1'b0, 1'b1, 1'b1, 4, 1, "ovl_b4");
        feed(1'b0, 1'b0, 1'b0, 2, 1, "ovl_b5");
        feed(1'b0, 1'b1, 1'b0, 3, 1, "ovl_b6");
        feed(1'b0, 1'b1, 1'b1, 4, 2, "ovl_b7");

        // Overlap off: restart after accept, history forgotten
        load(1'b0, 8'b0000_1011, 4'd4, 1'b0, "novl_load");
        feed(1'b0, 1'b1, 1'b0, 1, 0, "novl_b1");
        feed(1'b0, 1'b0, 1'b0, 2, 0, "novl_b2");
        feed(1'b0, 1'b1, 1'b0, 3, 0, "novl_b3");
        feed(1'b0, 1'b1, 1'b1, 4, 1, "novl_b4");
        feed(1'b0, 1'b0, 1'b0, 0, 1, "novl_b5");
        feed(1'b0, 1'b1, 1'b0, 1, 1, "novl_b6");
        feed(1'b0, 1'b1, 1'b0, 1, 1, "novl_b7");

        // Gating: en-low cycles between bits change nothing
        load(1'b0, 8'b0000_1011, 4'd4, 1'b1, "gate_load");
        feed(1'b0, 1'b1, 1'b0, 1, 0, "gate_b1");
        idle(1'b0, 1'b0, 1, 0, "gate_idle1");
        feed(1'b0, 1'b0, 1'b0, 2, 0, "gate_b2");
        idle(1'b0, 1'b0, 2, 0, "gate_idle2");
        idle(1'b0, 1'b0, 2, 0, "gate_idle3");
        feed(1'b0, 1'b1, 1'b0, 3, 0, "gate_b3");
        idle(1'b0, 1'b0, 3, 0, "gate_idle4");
        feed(1'b0, 1'b1, 1'b1, 4, 1, "gate_b4");
        idle(1'b0, 1'b1, 4, 1, "gate_hold1");
        idle(1'b0, 1'b1, 4, 1, "gate_hold2");

        // Saturation on the 2-bit counter instance, len 1 pattern 1
        load(1'b1, 8'h01, 4'd1, 1'b1, "sat_load");
        feed(1'b1, 1'b1, 1'b1, 1, 1, "sat_b1");
        feed(1'b1, 1'b1, 1'b1, 1, 2, "sat_b2");
        feed(1'b1, 1'b1, 1'b1, 1, 3, "sat_b3");
        feed(1'b1, 1'b1, 1'b1, 1, 3, "sat_b4");
        feed(1'b1, 1'b1, 1'b1, 1, 3, "sat_b5");
        idle(1'b1, 1'b1, 1, 3, "sat_hold");

        // Length clamp: 0 -> 1
        load(1'b0, 8'h01, 4'd0, 1'b1, "clamp0_load");
        feed(1'b0, 1'b0, 1'b0, 0, 0, "clamp0_b0");
        feed(1'b0, 1'b1, 1'b1, 1, 1, "clamp0_b1");
        feed(1'b0, 1'b1, 1'b1, 1, 2, "clamp0_b2");

        // Length clamp: 15 -> 8, pattern 10100101 grows one state per bit
        load(1'b0, 8'hA5, 4'd15, 1'b1, "clamp15_load");
        vec = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            feed(1'b0, vec[7 - i], (i == 7), i + 1, (i == 7) ? 1 : 0, "clamp15_bit");
        end

        // Mid-operation cfg_load with a coincident valid bit
        load(1'b0, 8'b0000_1011, 4'd4, 1'b1, "clr_load");
        feed(1'b0, 1'b1, 1'b0, 1, 0, "clr_b1");
        feed(1'b0, 1'b0, 1'b0, 2, 0, "clr_b2");
        feed(1'b0, 1'b1, 1'b0, 3, 0, "clr_b3");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "clr_load_with_en");
        feed(1'b0, 1'b1, 1'b0, 1, 0, "clr_after_b1");
        feed(1'b0, 1'b0, 1'b0, 2, 0, "clr_after_b2");
        feed(1'b0, 1'b1, 1'b0, 3, 0, "clr_after_b3");

        // Mid-operation rst: back to pattern 0, length MAX_LEN, overlap on
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "rst_with_en");
        for (int i = 0; i < 9; i++) begin
            feed(1'b0, 1'b0, (i >= 7), (i >= 7) ? 8 : i + 1, (i >= 7) ? i - 6 : 0, "rst_zero_bit");
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
